// File: rtl/mux_pipe_pkg.sv
// Shared types, default parameters and configuration legality helpers for the
// mux_pipe_arb forward-merge block.
package mux_pipe_pkg;

  localparam int unsigned DEF_WIDTH        = 128;
  localparam int unsigned DEF_NFWD         = 2;
  localparam int unsigned DEF_DEPTH        = 2;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

  // Legal configuration ranges
  localparam int unsigned NFWD_MIN  = 1;
  localparam int unsigned NFWD_MAX  = 8;
  localparam int unsigned DEPTH_MIN = 2;

  typedef logic [DEF_WIDTH-1:0]          beat_t;
  typedef logic [$clog2(DEF_NFWD)-1:0]   chan_idx_t;
  typedef logic [$clog2(DEF_DEPTH):0]    count_t;

  function automatic bit nfwd_legal(int unsigned n);
    return (n >= NFWD_MIN) && (n <= NFWD_MAX);
  endfunction

  function automatic bit depth_legal(int unsigned d);
    return (d >= DEPTH_MIN) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/mux_pipe_arb_if.sv
// Handshake bundle for mux_pipe_arb: bypass input, NFWD forward channels and
// the single merged output. slave = block view, master = environment view.
interface mux_pipe_arb_if
  import mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NFWD  = DEF_NFWD
);
  logic                  in_enq__ENA;
  logic [WIDTH-1:0]      in_enq_v;
  logic                  in_enq__RDY;
  logic [NFWD-1:0]       fwd_enq__ENA;
  logic [NFWD*WIDTH-1:0] fwd_enq_v;
  logic [NFWD-1:0]       fwd_enq__RDY;
  logic                  out_enq__ENA;
  logic [WIDTH-1:0]      out_enq_v;
  logic                  out_enq__RDY;

  modport slave (
    input  in_enq__ENA, in_enq_v, fwd_enq__ENA, fwd_enq_v, out_enq__RDY,
    output in_enq__RDY, fwd_enq__RDY, out_enq__ENA, out_enq_v
  );

  modport master (
    output in_enq__ENA, in_enq_v, fwd_enq__ENA, fwd_enq_v, out_enq__RDY,
    input  in_enq__RDY, fwd_enq__RDY, out_enq__ENA, out_enq_v
  );
endinterface

// File: rtl/mux_pipe_fifo.sv
// Registered-array FIFO for one forward channel. Enqueue is ignored when full,
// dequeue when empty; no enq->deq bypass, so `first` shows only stored beats.
module mux_pipe_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_v,
  input  logic             deq,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] first
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_enq, do_deq;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign do_enq = enq & ~full;
  assign do_deq = deq & ~empty;
  assign first  = mem[rd_ptr];

  // Payload storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk) begin
    if (do_enq) mem[wr_ptr] <= enq_v;
  end

  // Pointers wrap naturally mod DEPTH; occupancy tracks enq/deq balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      if (do_enq && !do_deq)      count <= count + 1'b1;
      else if (!do_enq && do_deq) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/mux_pipe_arb.sv
// Merges one zero-latency bypass input and NFWD buffered forward channels onto
// a single exclusive output. Bypass has priority; forward channels are served
// round-robin. Optional starvation guard: define MUX_PIPE_STARVE_GUARD_EN.
module mux_pipe_arb
  import mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NFWD  = DEF_NFWD,
  parameter int unsigned DEPTH = DEF_DEPTH
`ifdef MUX_PIPE_STARVE_GUARD_EN
  , parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
  input  logic           CLK,
  input  logic           nRST,
  mux_pipe_arb_if.slave  bus
);
  localparam int unsigned IW = (NFWD > 1) ? $clog2(NFWD) : 1;

  logic [NFWD-1:0]  full, empty, deq;
  logic [WIDTH-1:0] first [NFWD];
  logic [IW-1:0]    rr_ptr, win, cand;
  logic             in_rdy, byp_grant, fwd_grant, guard_block;

  for (genvar k = 0; k < NFWD; k++) begin : g_fifo
    mux_pipe_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (CLK),
      .rst_n (nRST),
      .enq   (bus.fwd_enq__ENA[k]),
      .enq_v (bus.fwd_enq_v[k*WIDTH +: WIDTH]),
      .deq   (deq[k]),
      .full  (full[k]),
      .empty (empty[k]),
      .first (first[k])
    );
  end

  // Ready signals are forced low while reset is asserted
  assign in_rdy           = nRST & bus.out_enq__RDY & ~guard_block;
  assign bus.in_enq__RDY  = in_rdy;
  assign bus.fwd_enq__RDY = nRST ? ~full : '0;

  // Grant selection: bypass first, else first non-empty FIFO from rr_ptr
  always_comb begin
    byp_grant = in_rdy & bus.in_enq__ENA;
    fwd_grant = 1'b0;
    win       = '0;
    cand      = '0;
    deq       = '0;
    if (nRST && bus.out_enq__RDY && !byp_grant) begin
      for (int unsigned i = 0; i < NFWD; i++) begin
        cand = IW'((32'(rr_ptr) + i) % NFWD);
        if (!fwd_grant && !empty[cand]) begin
          fwd_grant = 1'b1;
          win       = cand;
        end
      end
    end
    if (fwd_grant) deq[win] = 1'b1;
  end

  assign bus.out_enq__ENA = byp_grant | fwd_grant;
  assign bus.out_enq_v    = byp_grant ? bus.in_enq_v :
                            (fwd_grant ? first[win] : '0);

  // Round-robin pointer moves past the winner on forward grants only
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)          rr_ptr <= '0;
    else if (fwd_grant) rr_ptr <= (win == IW'(NFWD - 1)) ? '0 : win + 1'b1;
  end

`ifdef MUX_PIPE_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starving;

  assign guard_block = (starve_cnt == SW'(STARVE_LIMIT));
  assign starving    = ~&empty & bus.out_enq__RDY & byp_grant;

  // Counts consecutive bypass wins over waiting forward data; the count is
  // held at the limit until a forward grant actually happens
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)            starve_cnt <= '0;
    else if (fwd_grant)   starve_cnt <= '0;
    else if (guard_block) starve_cnt <= starve_cnt;
    else if (starving)    starve_cnt <= starve_cnt + 1'b1;
    else                  starve_cnt <= '0;
  end
`else
  assign guard_block = 1'b0;
`endif
endmodule

// File: tb/tb_mux_pipe_arb.sv
// Self-checking bench for mux_pipe_arb: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_mux_pipe_arb;
  import mux_pipe_pkg::*;

  localparam int unsigned W  = DEF_WIDTH;
  localparam int unsigned NF = DEF_NFWD;
  localparam int unsigned D  = DEF_DEPTH;
  localparam int unsigned SL = DEF_STARVE_LIMIT;
`ifdef MUX_PIPE_STARVE_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mux_pipe_arb_if #(.WIDTH(W), .NFWD(NF)) bus ();

  mux_pipe_arb #(.WIDTH(W), .NFWD(NF), .DEPTH(D)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Senders must never present a bypass beat without ready
  always @(posedge CLK) begin
    if (nRST === 1'b1)
      assert (!(bus.in_enq__ENA && !bus.in_enq__RDY))
      else begin
        bad++;
        $display("FAIL ena_without_rdy at %0t", $time);
      end
  end

  // ---------------- reference model ----------------
  beat_t mq [NF][$];
  int    rr, scnt;
  bit    p_in_rdy, p_ena;
  bit [NF-1:0] p_fwd_rdy;
  beat_t p_v;
  int    p_src;   // -2 idle, -1 bypass, else channel

  task automatic m_reset();
    for (int k = 0; k < NF; k++) mq[k].delete();
    rr   = 0;
    scnt = 0;
  endtask

  function automatic bit m_in_rdy();
    return bus.out_enq__RDY && !(GUARD_ON && scnt == SL);
  endfunction

  task automatic m_predict();
    p_in_rdy = m_in_rdy();
    for (int k = 0; k < NF; k++) p_fwd_rdy[k] = (mq[k].size() < D);
    p_src = -2;
    p_v   = '0;
    if (bus.out_enq__RDY) begin
      if (bus.in_enq__ENA && p_in_rdy) begin
        p_src = -1;
        p_v   = bus.in_enq_v;
      end else begin
        for (int i = 0; i < NF; i++) begin
          int k = (rr + i) % NF;
          if (p_src == -2 && mq[k].size() > 0) begin
            p_src = k;
            p_v   = mq[k][0];
          end
        end
      end
    end
    p_ena = (p_src != -2);
  endtask

  task automatic m_update();
    bit any_ne = 1'b0;
    bit gblk   = GUARD_ON && scnt == SL;
    bit [NF-1:0] acc;
    for (int k = 0; k < NF; k++) begin
      any_ne |= (mq[k].size() > 0);
      acc[k] = bus.fwd_enq__ENA[k] && (mq[k].size() < D);
    end
    if (p_src >= 0) begin
      void'(mq[p_src].pop_front());
      rr = (p_src + 1) % NF;
    end
    for (int k = 0; k < NF; k++)
      if (acc[k]) mq[k].push_back(bus.fwd_enq_v[k*W +: W]);
    if (p_src >= 0)                                     scnt = 0;
    else if (gblk)                                      scnt = scnt;
    else if (any_ne && bus.out_enq__RDY && p_src == -1) scnt++;
    else                                                scnt = 0;
  endtask

  // One clock: predict, sample away from the edge, advance model at the edge
  task automatic run_cycle();
    m_predict();
    #1;
    chk("in_rdy",  bus.in_enq__RDY,  p_in_rdy);
    chk("fwd_rdy", bus.fwd_enq__RDY, p_fwd_rdy);
    chk("out_ena", bus.out_enq__ENA, p_ena);
    chk("out_v",   bus.out_enq_v,    p_ena ? p_v : '0);
    @(posedge CLK);
    m_update();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.in_enq__ENA  = 1'b0;
    bus.in_enq_v     = '0;
    bus.fwd_enq__ENA = '0;
    bus.fwd_enq_v    = '0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_in_rdy"},  bus.in_enq__RDY,  '0);
    chk({tag, "_fwd_rdy"}, bus.fwd_enq__RDY, '0);
    chk({tag, "_out_ena"}, bus.out_enq__ENA, '0);
    chk({tag, "_out_v"},   bus.out_enq_v,    '0);
  endtask

  // Called at a negedge; returns at a negedge with reset released
  task automatic do_reset();
    idle_inputs();
    bus.out_enq__RDY = 1'b1;
    nRST = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    m_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic           in_ena;
    logic [W-1:0]   in_v;
    logic [NF-1:0]  fwd_ena;
    logic [NF*W-1:0] fwd_v;
    logic           out_rdy;
    logic           e_ena;
    logic [W-1:0]   e_v;
    logic           e_in_rdy;
    logic [NF-1:0]  e_fwd_rdy;
  } vec_t;

  function automatic vec_t mk(int ie, int iv, int fe, int f0, int f1, int ordy,
                              int ee, int ev, int eir, int efr);
    vec_t v;
    v.in_ena    = 1'(ie);
    v.in_v      = W'(iv);
    v.fwd_ena   = NF'(fe);
    v.fwd_v     = '0;
    v.fwd_v[0 +: W] = W'(f0);
    v.fwd_v[W +: W] = W'(f1);
    v.out_rdy   = 1'(ordy);
    v.e_ena     = 1'(ee);
    v.e_v       = W'(ev);
    v.e_in_rdy  = 1'(eir);
    v.e_fwd_rdy = NF'(efr);
    return v;
  endfunction

  vec_t tbl [14];

  initial begin
    int unsigned nxt;
    bit exp_guard;

    nRST = 1'b0;
    idle_inputs();
    bus.out_enq__RDY = 1'b1;
    m_reset();
    @(negedge CLK);
    do_reset();

    //         ie iv     fe f0    f1    ordy  ee ev     eir efr
    tbl[0]  = mk(1, 'hA5, 0, 0,    0,    1,    1, 'hA5,  1,  3);
    tbl[1]  = mk(0, 0,    3, 'h10, 'h20, 0,    0, 0,     0,  3);
    tbl[2]  = mk(0, 0,    3, 'h11, 'h21, 0,    0, 0,     0,  3);
    tbl[3]  = mk(1, 'hA6, 0, 0,    0,    1,    1, 'hA6,  1,  0);
    tbl[4]  = mk(0, 0,    0, 0,    0,    1,    1, 'h10,  1,  0);
    tbl[5]  = mk(0, 0,    0, 0,    0,    1,    1, 'h20,  1,  1);
    tbl[6]  = mk(0, 0,    0, 0,    0,    1,    1, 'h11,  1,  3);
    tbl[7]  = mk(0, 0,    0, 0,    0,    1,    1, 'h21,  1,  3);
    tbl[8]  = mk(0, 0,    1, 'h1,  0,    0,    0, 0,     0,  3);
    tbl[9]  = mk(0, 0,    1, 'h2,  0,    0,    0, 0,     0,  3);
    tbl[10] = mk(0, 0,    0, 0,    0,    0,    0, 0,     0,  2);
    tbl[11] = mk(0, 0,    0, 0,    0,    1,    1, 'h1,   1,  2);
    tbl[12] = mk(0, 0,    0, 0,    0,    1,    1, 'h2,   1,  3);
    tbl[13] = mk(0, 0,    0, 0,    0,    1,    0, 0,     1,  3);

    for (int i = 0; i < 14; i++) begin
      bus.in_enq__ENA  = tbl[i].in_ena;
      bus.in_enq_v     = tbl[i].in_v;
      bus.fwd_enq__ENA = tbl[i].fwd_ena;
      bus.fwd_enq_v    = tbl[i].fwd_v;
      bus.out_enq__RDY = tbl[i].out_rdy;
      #1;
      chk($sformatf("tbl%0d_out_ena", i), bus.out_enq__ENA, tbl[i].e_ena);
      chk($sformatf("tbl%0d_out_v", i),   bus.out_enq_v,    tbl[i].e_v);
      chk($sformatf("tbl%0d_in_rdy", i),  bus.in_enq__RDY,  tbl[i].e_in_rdy);
      chk($sformatf("tbl%0d_fwd_rdy", i), bus.fwd_enq__RDY, tbl[i].e_fwd_rdy);
      @(posedge CLK);
      @(negedge CLK);
    end

    // Starvation: continuous bypass while ch1 holds one beat
    do_reset();
    idle_inputs();
    bus.out_enq__RDY = 1'b0;
    bus.fwd_enq__ENA = 2'b10;
    bus.fwd_enq_v[W +: W] = W'('h20);
    run_cycle();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      bus.out_enq__RDY = 1'b1;
      bus.in_enq_v     = W'('hB0 + i);
      bus.in_enq__ENA  = m_in_rdy();
      exp_guard = GUARD_ON && (i == SL);
      #1;
      chk($sformatf("starve%0d_in_rdy", i), bus.in_enq__RDY, !exp_guard);
      chk($sformatf("starve%0d_out_v", i), bus.out_enq_v,
          exp_guard ? W'('h20) : W'('hB0 + i));
      run_cycle();
    end
    idle_inputs();
    bus.out_enq__RDY = 1'b1;
    run_cycle();

    // Steady enq+deq on ch0 starting from full: order kept, level constant
    do_reset();
    idle_inputs();
    bus.out_enq__RDY = 1'b0;
    bus.fwd_enq__ENA = 2'b01;
    bus.fwd_enq_v[0 +: W] = W'(1);
    run_cycle();
    bus.fwd_enq_v[0 +: W] = W'(2);
    run_cycle();
    nxt = 3;
    for (int i = 0; i < 10; i++) begin
      bus.out_enq__RDY = 1'b1;
      m_predict();
      bus.fwd_enq__ENA = {1'b0, p_fwd_rdy[0]};
      bus.fwd_enq_v[0 +: W] = W'(nxt);
      #1;
      chk($sformatf("flow%0d_out_v", i),   bus.out_enq_v, W'(i + 1));
      chk($sformatf("flow%0d_fwd_rdy", i), bus.fwd_enq__RDY[0], (i > 0));
      if (p_fwd_rdy[0]) nxt++;
      run_cycle();
    end

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.out_enq__RDY = ($urandom_range(0, 3) != 0);
      bus.fwd_enq__ENA = NF'($urandom);
      bus.fwd_enq_v    = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
      bus.in_enq_v     = {$urandom, $urandom, $urandom, $urandom};
      bus.in_enq__ENA  = ($urandom_range(0, 2) == 0) && m_in_rdy();
      run_cycle();
    end

    // Asynchronous reset mid-stream
    do_reset();
    idle_inputs();
    bus.out_enq__RDY = 1'b0;
    bus.fwd_enq__ENA = 2'b11;
    bus.fwd_enq_v    = {W'('h51), W'('h50)};
    run_cycle();
    run_cycle();
    idle_inputs();
    bus.out_enq__RDY = 1'b1;
    run_cycle();
    #2;
    nRST = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    m_reset();
    run_cycle();
    bus.out_enq__RDY = 1'b0;
    bus.fwd_enq__ENA = 2'b11;
    bus.fwd_enq_v    = {W'('h40), W'('h30)};
    run_cycle();
    idle_inputs();
    bus.out_enq__RDY = 1'b1;
    #1;
    chk("post_rst_first_grant", bus.out_enq_v, W'('h30));
    run_cycle();
    run_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
